// File: rtl/regfile_wb_queue_if.sv
// Writeback request, register-file write and decode-hazard signals between
// the result producers/decode stage and the writeback queue.
interface regfile_wb_queue_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          D_En;
    logic [AW-1:0] D_Addr;
    logic [DW-1:0] D;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] rd_addr_t;
    logic          hazard_s;
    logic          hazard_t;
    logic          idle;

    modport master (
        output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
               rd_addr_s, rd_addr_t,
        input  mem_ready, alu_ready, D_En, D_Addr, D, hazard_s, hazard_t, idle
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
               rd_addr_s, rd_addr_t,
        output mem_ready, alu_ready, D_En, D_Addr, D, hazard_s, hazard_t, idle
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO feeding the register-file write port from the memory
// and ALU result paths, with pending-write hazard reporting for decode.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input logic clk,
    input logic reset,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]  r_addr [DEPTH];
    logic [DW-1:0]  r_data [DEPTH];
    logic           r_den;
    logic [AW-1:0]  r_daddr;
    logic [DW-1:0]  r_d;

    logic [CW-1:0]  w_free;
    logic           w_mem_ready;
    logic           w_alu_ready;
    logic           w_push_m;
    logic           w_push_a;
    logic           w_pop;
    logic [PW-1:0]  w_slot_a;
    logic [DEPTH-1:0] w_vld_next;
    logic           w_hit_s;
    logic           w_hit_t;

    // Ready reserves a second slot for the ALU only when mem is also requesting.
    assign w_free      = CW'(DEPTH) - r_count;
    assign w_mem_ready = (w_free >= CW'(1));
    assign w_alu_ready = bus.mem_valid ? (w_free >= CW'(2)) : (w_free >= CW'(1));

    assign w_push_m = bus.mem_valid & w_mem_ready & (bus.mem_addr != '0);
    assign w_push_a = bus.alu_valid & w_alu_ready & (bus.alu_addr != '0);
    assign w_pop    = (r_count != '0);
    assign w_slot_a = w_push_m ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

    always_comb begin
        w_vld_next = r_vld;
        if (w_pop)    w_vld_next[r_rd_ptr] = 1'b0;
        if (w_push_m) w_vld_next[r_wr_ptr] = 1'b1;
        if (w_push_a) w_vld_next[w_slot_a] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push_m) begin
            r_addr[r_wr_ptr] <= bus.mem_addr;
            r_data[r_wr_ptr] <= bus.mem_data;
        end
        if (w_push_a) begin
            r_addr[w_slot_a] <= bus.alu_addr;
            r_data[w_slot_a] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
            r_den    <= 1'b0;
            r_daddr  <= '0;
            r_d      <= '0;
        end else begin
            r_count  <= r_count + CW'(w_push_m) + CW'(w_push_a) - CW'(w_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_push_m) + PW'(w_push_a);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_vld    <= w_vld_next;
            if (w_pop) begin
                r_den   <= 1'b1;
                r_daddr <= r_addr[r_rd_ptr];
                r_d     <= r_data[r_rd_ptr];
            end else begin
                r_den   <= 1'b0;
            end
        end
    end

    // Only queued entries and the write in flight count; this cycle's requests do not.
    always_comb begin
        w_hit_s = r_den & (r_daddr == bus.rd_addr_s);
        w_hit_t = r_den & (r_daddr == bus.rd_addr_t);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == bus.rd_addr_s)) w_hit_s = 1'b1;
            if (r_vld[i] && (r_addr[i] == bus.rd_addr_t)) w_hit_t = 1'b1;
        end
    end

    assign bus.mem_ready = w_mem_ready;
    assign bus.alu_ready = w_alu_ready;
    assign bus.D_En      = r_den;
    assign bus.D_Addr    = r_daddr;
    assign bus.D         = r_d;
    assign bus.hazard_s  = (bus.rd_addr_s != '0) & w_hit_s;
    assign bus.hazard_t  = (bus.rd_addr_t != '0) & w_hit_t;
    assign bus.idle      = (r_count == '0) & ~r_den;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized and directed checks of the writeback queue against a queue-based
// model of accepted writes and the register-file write port.
module tb_regfile_wb_queue;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_queue_if #(.DW(32), .AW(5)) bus ();

    regfile_wb_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    logic        m_den = 1'b0;
    logic [4:0]  m_daddr = '0;
    logic [31:0] m_d = '0;
    logic        obs_mr, obs_ar;
    ent_t        obs_log[$];
    ent_t        acc_log[$];

    function automatic logic haz(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_den && m_daddr == r) return 1'b1;
        foreach (q[i]) if (q[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic [4:0] rs, input logic [4:0] rt);
        int   free;
        logic er_m, er_a;
        @(negedge clk);
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.rd_addr_s = rs; bus.rd_addr_t = rt;
        #1;
        free = 4 - q.size();
        er_m = (free >= 1);
        er_a = mv ? (free >= 2) : (free >= 1);
        obs_mr = bus.mem_ready;
        obs_ar = bus.alu_ready;
        checks += 5;
        if (obs_mr !== er_m) begin errors++; $display("FAIL mem_ready got %b want %b", obs_mr, er_m); end
        if (obs_ar !== er_a) begin errors++; $display("FAIL alu_ready got %b want %b", obs_ar, er_a); end
        if (bus.hazard_s !== haz(rs)) begin errors++; $display("FAIL hazard_s got %b want %b (rs=%0d)", bus.hazard_s, haz(rs), rs); end
        if (bus.hazard_t !== haz(rt)) begin errors++; $display("FAIL hazard_t got %b want %b (rt=%0d)", bus.hazard_t, haz(rt), rt); end
        if (bus.idle !== (q.size() == 0 && !m_den)) begin errors++; $display("FAIL idle got %b want %b", bus.idle, (q.size() == 0 && !m_den)); end
        @(posedge clk);
        if (q.size() > 0) begin
            ent_t h;
            h = q.pop_front();
            m_den = 1'b1; m_daddr = h.a; m_d = h.d;
        end else begin
            m_den = 1'b0;
        end
        if (mv && er_m && ma != 5'd0) begin q.push_back('{ma, md}); acc_log.push_back('{ma, md}); end
        if (av && er_a && aa != 5'd0) begin q.push_back('{aa, ad}); acc_log.push_back('{aa, ad}); end
        #1;
        if (bus.D_En === 1'b1) obs_log.push_back('{bus.D_Addr, bus.D});
        checks += 3;
        if (bus.D_En !== m_den) begin errors++; $display("FAIL D_En got %b want %b", bus.D_En, m_den); end
        if (bus.D_Addr !== m_daddr) begin errors++; $display("FAIL D_Addr got %0d want %0d", bus.D_Addr, m_daddr); end
        if (bus.D !== m_d) begin errors++; $display("FAIL D got %h want %h", bus.D, m_d); end
    endtask

    task automatic idle_step(input logic [4:0] rs, input logic [4:0] rt);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs, rt);
    endtask

    task automatic test_reset;
        bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.rd_addr_s = 0; bus.rd_addr_t = 0;
        #12;
        checks += 4;
        if (bus.D_En !== 1'b0) begin errors++; $display("FAIL rst_den got %b want 0", bus.D_En); end
        if (bus.D_Addr !== 5'd0) begin errors++; $display("FAIL rst_daddr got %0d want 0", bus.D_Addr); end
        if (bus.D !== 32'd0) begin errors++; $display("FAIL rst_d got %h want 0", bus.D); end
        if (bus.idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", bus.idle); end
        @(negedge clk); reset = 1'b0;
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
        step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd3, 5'd4);
        bus.mem_valid = 0; bus.alu_valid = 0;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        q.delete(); m_den = 1'b0; m_daddr = '0; m_d = '0;
        checks += 4;
        if (bus.D_En !== 1'b0) begin errors++; $display("FAIL midrst_den got %b want 0", bus.D_En); end
        if (bus.idle !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b want 1", bus.idle); end
        if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL midrst_mem_ready got %b want 1", bus.mem_ready); end
        if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL midrst_alu_ready got %b want 1", bus.alu_ready); end
        @(negedge clk); reset = 1'b0;
        obs_log.delete();
        repeat (4) idle_step(5'd3, 5'd4);
        checks++;
        if (obs_log.size() != 0) begin errors++; $display("FAIL rst_no_writes got %0d writes want 0", obs_log.size()); end
    endtask

    task automatic test_single;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        idle_step(5'd5, 5'd0);
        checks += 4;
        if (bus.D_En !== 1'b1) begin errors++; $display("FAIL single_den got %b want 1", bus.D_En); end
        if (bus.D_Addr !== 5'd5) begin errors++; $display("FAIL single_addr got %0d want 5", bus.D_Addr); end
        if (bus.D !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", bus.D); end
        if (bus.hazard_s !== 1'b1) begin errors++; $display("FAIL single_hazard got %b want 1", bus.hazard_s); end
        idle_step(5'd5, 5'd0);
        idle_step(5'd5, 5'd0);
    endtask

    task automatic test_simultaneous;
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
        idle_step(5'd3, 5'd4);
        checks += 2;
        if (bus.D_Addr !== 5'd3 || bus.D !== 32'h11) begin errors++; $display("FAIL simul_first got %0d/%h want 3/11", bus.D_Addr, bus.D); end
        idle_step(5'd3, 5'd4);
        if (bus.D_Addr !== 5'd4 || bus.D !== 32'h22) begin errors++; $display("FAIL simul_second got %0d/%h want 4/22", bus.D_Addr, bus.D); end
        idle_step(5'd0, 5'd0);
    endtask

    task automatic test_full;
        obs_log.delete();
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 5'd1, 5'd2);
        step(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, 5'd2, 5'd3);
        step(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, 5'd4, 5'd6);
        checks += 2;
        if (obs_ar !== 1'b0) begin errors++; $display("FAIL full_alu_ready got %b want 0", obs_ar); end
        if (obs_mr !== 1'b1) begin errors++; $display("FAIL full_mem_ready got %b want 1", obs_mr); end
        repeat (5) idle_step(5'd5, 5'd6);
        checks++;
        if (obs_log.size() != 5) begin errors++; $display("FAIL full_count got %0d writes want 5", obs_log.size()); end
        for (int i = 0; i < 5 && i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i].a !== 5'(i + 1)) begin errors++; $display("FAIL full_order[%0d] got %0d want %0d", i, obs_log[i].a, i + 1); end
        end
    endtask

    task automatic test_r0;
        obs_log.delete();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
        checks++;
        if (obs_ar !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", obs_ar); end
        repeat (3) idle_step(5'd0, 5'd0);
        checks += 2;
        if (obs_log.size() != 0) begin errors++; $display("FAIL r0_no_write got %0d writes want 0", obs_log.size()); end
        if (bus.hazard_s !== 1'b0) begin errors++; $display("FAIL r0_hazard got %b want 0", bus.hazard_s); end
    endtask

    task automatic test_wrap;
        int sent;
        obs_log.delete();
        acc_log.delete();
        sent = 0;
        while (sent < 10) begin
            logic [4:0] a;
            a = 5'($urandom_range(1, 31));
            step(1'b0, 5'd0, 32'd0, 1'b1, a, $urandom, a, 5'($urandom_range(0, 31)));
            sent++;
            if ($urandom_range(0, 2) == 0) idle_step(5'($urandom_range(0, 31)), 5'd0);
        end
        repeat (4) idle_step(5'd0, 5'd0);
        checks++;
        if (obs_log.size() != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", obs_log.size()); end
        for (int i = 0; i < acc_log.size() && i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== acc_log[i]) begin errors++; $display("FAIL wrap_seq[%0d] got %0d/%h want %0d/%h", i, obs_log[i].a, obs_log[i].d, acc_log[i].a, acc_log[i].d); end
        end
    endtask

    task automatic test_random;
        obs_log.delete();
        acc_log.delete();
        for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (5) idle_step(5'd0, 5'd0);
        checks++;
        if (obs_log.size() != acc_log.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_log.size(), acc_log.size()); end
        for (int i = 0; i < acc_log.size() && i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== acc_log[i]) begin errors++; $display("FAIL rand_seq[%0d] got %0d/%h want %0d/%h", i, obs_log[i].a, obs_log[i].d, acc_log[i].a, acc_log[i].d); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_full();
        test_r0();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
